// File: rtl/alu_logic_pipe_pkg.sv
// Shared ALU definitions: function-code width, the logic-class prefix and
// the five logic op codes carried in ALUFun[3:0].
package alu_logic_pipe_pkg;

    localparam int ALUFUN_W = 6;

    // ALUFun[5:4] value that selects the logic unit
    localparam logic [1:0] FUN_CLASS_LOGIC = 2'b01;

    typedef enum logic [3:0] {
        OP_AND   = 4'b1000,
        OP_OR    = 4'b1110,
        OP_XOR   = 4'b0110,
        OP_NOR   = 4'b0001,
        OP_PASSA = 4'b1010
    } logic_op_e;

endpackage

// File: rtl/alu_logic_pipe_logic_core.sv
// Combinational decode + compute for the logic unit. Codes outside the logic
// class, or unknown low nibbles, yield S=0 with illegal set.
module alu_logic_pipe_logic_core
    import alu_logic_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALUFUN_W-1:0] alufun,
    output logic [WIDTH-1:0]    s,
    output logic                illegal
);

    // decode the function code and pick the bitwise result
    always_comb begin
        s       = '0;
        illegal = 1'b1;
        if (alufun[5:4] == FUN_CLASS_LOGIC) begin
            illegal = 1'b0;
            case (alufun[3:0])
                OP_AND:   s = a & b;
                OP_OR:    s = a | b;
                OP_XOR:   s = a ^ b;
                OP_NOR:   s = ~(a | b);
                OP_PASSA: s = a;
                default: begin
                    s       = '0;
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage pipelined logic unit with valid/ready on both sides, backpressure
// and synchronous flush. s1 captures operands, s2 captures the result.
// Optional feature: define LOGIC_ZERO_FLAG_EN to add the registered zero flag.
module alu_logic_pipe
    import alu_logic_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [ALUFUN_W-1:0] ALUFun,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    S,
    output logic                illegal
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    output logic                zero
`endif
);

    localparam int STAGES = 2;

    logic [STAGES:1]     vld_pipe;   // [1]=s1_valid, [2]=s2_valid
    logic [WIDTH-1:0]    s1_a, s1_b;
    logic [ALUFUN_W-1:0] s1_fun;
    logic [WIDTH-1:0]    core_s;
    logic                core_illegal;
    logic                s1_adv, accept;

    // s1 moves into s2 whenever s2 is empty or is being drained this cycle
    assign s1_adv    = vld_pipe[1] && (!vld_pipe[2] || out_ready);
    assign in_ready  = !vld_pipe[1] || s1_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_pipe[2];

    alu_logic_pipe_logic_core #(.WIDTH(WIDTH)) u_core (
        .a       (s1_a),
        .b       (s1_b),
        .alufun  (s1_fun),
        .s       (core_s),
        .illegal (core_illegal)
    );

    // valid bits: flush beats any accept or output handshake in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            if (accept)
                vld_pipe[1] <= 1'b1;
            else if (s1_adv)
                vld_pipe[1] <= 1'b0;

            if (s1_adv)
                vld_pipe[2] <= 1'b1;
            else if (out_ready)
                vld_pipe[2] <= 1'b0;
        end
    end

    // s1 operand capture on accept; holds while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_fun <= '0;
        end else if (accept) begin
            s1_a   <= A;
            s1_b   <= B;
            s1_fun <= ALUFun;
        end
    end

    // s2 result capture when s1 advances; holds stable under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            S       <= '0;
            illegal <= 1'b0;
        end else if (s1_adv) begin
            S       <= core_s;
            illegal <= core_illegal;
        end
    end

`ifdef LOGIC_ZERO_FLAG_EN
    // zero flag registered alongside S (set for illegal ops too, since S=0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            zero <= 1'b0;
        else if (s1_adv)
            zero <= (core_s == '0);
    end
`endif

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Scoreboard bench for alu_logic_pipe: a 32-bit and an 8-bit instance.
// Drivers push hand-computed expectations on accept; a negedge monitor pops
// and compares on every output handshake.
module tb_alu_logic_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // 32-bit instance
    logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0, ill32;
    logic [31:0] A = 0, B = 0, S;
    logic [5:0]  ALUFun = 0;
    // 8-bit instance
    logic        in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 1, ill8;
    logic [7:0]  A8 = 0, B8 = 0, S8;
    logic [5:0]  ALUFun8 = 0;
`ifdef LOGIC_ZERO_FLAG_EN
    logic zero32, zero8;
`endif

    alu_logic_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUFun(ALUFun), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .illegal(ill32)
`ifdef LOGIC_ZERO_FLAG_EN
        , .zero(zero32)
`endif
    );

    alu_logic_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .ALUFun(ALUFun8), .flush(1'b0), .out_valid(out_valid8),
        .out_ready(out_ready8), .S(S8), .illegal(ill8)
`ifdef LOGIC_ZERO_FLAG_EN
        , .zero(zero8)
`endif
    );

    typedef struct {
        logic [31:0] s;
        logic        ill;
        logic        zr;
        int          cyc;   // expected monitor cycle, -1 = don't care
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int n_cmp = 0, n_bad = 0, pops32 = 0;

    localparam logic [5:0] F_AND = 6'b011000, F_OR = 6'b011110, F_XOR = 6'b010110,
                           F_NOR = 6'b010001, F_PA = 6'b011010, F_BAD = 6'b000000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    // monitor: compare every output handshake against the scoreboard
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !flush) begin
            pops32++;
            if (q32.size() == 0) begin
                timeout("unexpected output 32");
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("S32", S, e.s);
                chk("illegal32", {31'd0, ill32}, {31'd0, e.ill});
`ifdef LOGIC_ZERO_FLAG_EN
                chk("zero32", {31'd0, zero32}, {31'd0, e.zr});
`endif
                if (e.cyc >= 0) chk("latency32", cyc, e.cyc);
            end
        end
        if (!reset && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                timeout("unexpected output 8");
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("S8", {24'd0, S8}, e.s);
                chk("illegal8", {31'd0, ill8}, {31'd0, e.ill});
`ifdef LOGIC_ZERO_FLAG_EN
                chk("zero8", {31'd0, zero8}, {31'd0, e.zr});
`endif
            end
        end
    end

    // drive one op into the 32-bit DUT; call #1 after a posedge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                        input logic [31:0] es, input logic ei, input logic ez, input bit lat);
        int n = 0;
        A = a; B = b; ALUFun = f; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 20) begin n++; @(negedge clk); end
        if (!in_ready) timeout("send32 accept");
        else q32.push_back('{s: es, ill: ei, zr: ez, cyc: lat ? cyc + 2 : -1});
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [5:0] f,
                         input logic [7:0] es, input logic ei, input logic ez);
        int n = 0;
        A8 = a; B8 = b; ALUFun8 = f; in_valid8 = 1;
        @(negedge clk);
        while (!in_ready8 && n < 20) begin n++; @(negedge clk); end
        if (!in_ready8) timeout("send8 accept");
        else q8.push_back('{s: {24'd0, es}, ill: ei, zr: ez, cyc: -1});
        @(posedge clk); #1;
        in_valid8 = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 30) begin n++; @(posedge clk); end
        if (q32.size() != 0 || q8.size() != 0) timeout("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] held;
        bit          have;
        int          acc, k, p0;
        logic [31:0] sa[3], sb[3], se[3];
        logic [5:0]  sf[3];

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset S", S, 32'd0);
        chk("reset illegal", {31'd0, ill32}, 32'd0);
        reset = 0;
        #1 chk("in_ready after reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // 1: streamed ops, latency 2, one per cycle
        out_ready = 1;
        send(32'h1, 32'hFFFF_FFFE, F_AND, 32'h0000_0000, 0, 1, 1);
        send(32'h1, 32'hFFFF_FFFE, F_OR,  32'hFFFF_FFFF, 0, 0, 1);
        send(32'h1, 32'hFFFF_FFFE, F_XOR, 32'hFFFF_FFFF, 0, 0, 1);
        send(32'h1, 32'hFFFF_FFFE, F_NOR, 32'h0000_0000, 0, 1, 1);
        send(32'h1, 32'hFFFF_FFFE, F_PA,  32'h0000_0001, 0, 0, 1);
        drain();

        // 2: illegal code then a legal OR
        send(32'hA5A5_A5A5, 32'hA5A5_A5A5, F_BAD, 32'h0, 1, 1, 0);
        send(32'hA5A5_A5A5, 32'hA5A5_A5A5, F_OR,  32'hA5A5_A5A5, 0, 0, 0);
        drain();

        // 3: backpressure with in_valid held
        sa = '{32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00};
        sb = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
        sf = '{F_AND, F_XOR, F_OR};
        se = '{32'h0F00_0F00, 32'hF00F_F00F, 32'hFF0F_FF0F};
        out_ready = 0; acc = 0; k = 0; have = 0; held = '0;
        A = sa[0]; B = sb[0]; ALUFun = sf[0]; in_valid = 1;
        for (int c = 0; c < 4; c++) begin
            bit took;
            @(negedge clk);
            took = in_ready;
            if (took) begin
                q32.push_back('{s: se[k], ill: 0, zr: 0, cyc: -1});
                acc++;
            end
            if (out_valid) begin
                if (!have) begin held = S; have = 1; end
                else chk("stall S stable", S, held);
            end
            @(posedge clk); #1;
            if (took) begin k++; A = sa[k]; B = sb[k]; ALUFun = sf[k]; end
        end
        chk("accepted under stall", acc, 2);
        @(negedge clk);
        chk("in_ready under stall", {31'd0, in_ready}, 32'd0);
        chk("stall S value", S, se[0]);
        @(posedge clk); #1;
        out_ready = 1;
        in_valid = 0;
        send(sa[2], sb[2], sf[2], se[2], 0, 0, 0);
        drain();

        // 4: flush with s1, s2 full and a simultaneous in_valid
        out_ready = 0;
        A = 32'h1111_1111; B = 32'h2222_2222; ALUFun = F_OR; in_valid = 1;
        @(posedge clk); #1;
        ALUFun = F_XOR;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre-flush out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        ALUFun = F_AND; out_ready = 1; flush = 1; p0 = pops32;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(posedge clk);
        #1 chk("flushed ops emerged", pops32 - p0, 0);

        // 5: async reset mid-stall
        out_ready = 0;
        A = 32'h1234_5678; B = 32'h0; ALUFun = F_PA; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("stall before reset", {31'd0, out_valid}, 32'd1);
        #2 reset = 1;
        #1 chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async reset S", S, 32'd0);
        #1 reset = 0;
        @(posedge clk); #1;
        out_ready = 1;
        send(32'hF0F0_F0F0, 32'hFFFF_0000, F_XOR, 32'h0F0F_F0F0, 0, 0, 0);
        drain();

        // 6: WIDTH=8 instance
        send8(8'h0F, 8'hF0, F_NOR, 8'h00, 0, 1);
        send8(8'h0F, 8'hF0, F_OR,  8'hFF, 0, 0);
        drain();

        chk("q32 empty", q32.size(), 0);
        chk("q8 empty", q8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
